// File: rtl/half_duplex_link_ctrl.sv
// Half-duplex single-wire link master: sends a framed request, turns the line
// around, then hunts for and deserializes the peripheral's framed response.
module half_duplex_link_ctrl #(
    parameter int DATA_W   = 8,
    parameter int CLKDIV   = 4,
    parameter int TURN_CYC = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_err,
    output logic              line_out,
    output logic              line_oe,
    input  logic              line_in
);

    localparam int TMO_CYC = TIMEOUT * CLKDIV;
    localparam int CYC_MAX = (CLKDIV > TURN_CYC) ? CLKDIV : TURN_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 3);
    localparam int TMO_W   = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TX    = 3'd1,
        ST_TURN  = 3'd2,
        ST_HUNT  = 3'd3,
        ST_START = 3'd4,
        ST_RX    = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [CYC_W-1:0]    cyc_r, cyc_s;
    logic [BIT_W-1:0]    bit_r, bit_s;
    logic [TMO_W-1:0]    tmo_r, tmo_s;
    logic [DATA_W+1:0]   tx_sh_r, tx_sh_s;
    logic [DATA_W-1:0]   rx_sh_r, rx_sh_s;
    logic                sync1_r, sync2_r;
    logic                line_s;
    logic                line_out_r, line_out_s;
    logic                line_oe_r, line_oe_s;
    logic                tx_ready_r, tx_ready_s;
    logic                rx_valid_r, rx_valid_s;
    logic                rx_err_r, rx_err_s;
    logic [DATA_W-1:0]   rx_data_r, rx_data_s;
    logic [TMO_W-1:0]    tmo_inc_s;

    // Two-flop synchronizer on the shared line; idles high like the pull-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= line_in;
            sync2_r <= sync1_r;
        end
    end

    assign line_s = sync2_r;

    // Timeout keeps counting through a rejected start bit, so it saturates rather than wraps.
    assign tmo_inc_s = (tmo_r == TMO_W'(TMO_CYC - 1)) ? tmo_r : tmo_r + TMO_W'(1);

    // Next-state and next-output logic for the link FSM.
    always_comb begin
        state_s    = state_r;
        cyc_s      = cyc_r;
        bit_s      = bit_r;
        tmo_s      = tmo_r;
        tx_sh_s    = tx_sh_r;
        rx_sh_s    = rx_sh_r;
        line_out_s = 1'b1;
        line_oe_s  = 1'b0;
        rx_valid_s = 1'b0;
        rx_err_s   = rx_err_r;
        rx_data_s  = rx_data_r;
        case (state_r)
            ST_IDLE: begin
                if (tx_valid && tx_ready_r) begin
                    state_s    = ST_TX;
                    tx_sh_s    = {1'b1, tx_data, 1'b0};
                    cyc_s      = {CYC_W{1'b0}};
                    bit_s      = {BIT_W{1'b0}};
                    line_oe_s  = 1'b1;
                    line_out_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TX: begin
                line_oe_s  = 1'b1;
                line_out_s = tx_sh_r[0];
                if (cyc_r == CYC_W'(CLKDIV - 1)) begin
                    cyc_s = {CYC_W{1'b0}};
                    if (bit_r == BIT_W'(DATA_W + 1)) begin
                        state_s    = ST_TURN;
                        line_oe_s  = 1'b0;
                        line_out_s = 1'b1;
                    end else begin
                        bit_s      = bit_r + BIT_W'(1);
                        tx_sh_s    = {1'b1, tx_sh_r[DATA_W+1:1]};
                        line_out_s = tx_sh_r[1];
                    end
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            ST_TURN: begin
                if (cyc_r == CYC_W'(TURN_CYC - 1)) begin
                    state_s = ST_HUNT;
                    cyc_s   = {CYC_W{1'b0}};
                    tmo_s   = {TMO_W{1'b0}};
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            ST_HUNT: begin
                tmo_s = tmo_inc_s;
                if (tmo_r == TMO_W'(TMO_CYC - 1)) begin
                    state_s    = ST_IDLE;
                    rx_valid_s = 1'b1;
                    rx_err_s   = 1'b1;
                    rx_data_s  = {DATA_W{1'b0}};
                end else if (!line_s) begin
                    state_s = ST_START;
                    cyc_s   = {CYC_W{1'b0}};
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_START: begin
                tmo_s = tmo_inc_s;
                if (cyc_r == CYC_W'(CLKDIV / 2 - 1)) begin
                    cyc_s = {CYC_W{1'b0}};
                    if (line_s) begin
                        state_s = ST_HUNT;
                    end else begin
                        state_s = ST_RX;
                        bit_s   = {BIT_W{1'b0}};
                    end
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            ST_RX: begin
                if (cyc_r == CYC_W'(CLKDIV - 1)) begin
                    cyc_s = {CYC_W{1'b0}};
                    if (bit_r == BIT_W'(DATA_W)) begin
                        state_s    = ST_IDLE;
                        rx_valid_s = 1'b1;
                        rx_err_s   = ~line_s;
                        rx_data_s  = rx_sh_r;
                    end else begin
                        rx_sh_s = {line_s, rx_sh_r[DATA_W-1:1]};
                        bit_s   = bit_r + BIT_W'(1);
                    end
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        tx_ready_s = (state_s == ST_IDLE);
    end

    // State and registered outputs; reset releases the line immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cyc_r      <= {CYC_W{1'b0}};
            bit_r      <= {BIT_W{1'b0}};
            tmo_r      <= {TMO_W{1'b0}};
            tx_sh_r    <= {(DATA_W + 2){1'b1}};
            rx_sh_r    <= {DATA_W{1'b0}};
            line_out_r <= 1'b1;
            line_oe_r  <= 1'b0;
            tx_ready_r <= 1'b1;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            rx_data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            cyc_r      <= cyc_s;
            bit_r      <= bit_s;
            tmo_r      <= tmo_s;
            tx_sh_r    <= tx_sh_s;
            rx_sh_r    <= rx_sh_s;
            line_out_r <= line_out_s;
            line_oe_r  <= line_oe_s;
            tx_ready_r <= tx_ready_s;
            rx_valid_r <= rx_valid_s;
            rx_err_r   <= rx_err_s;
            rx_data_r  <= rx_data_s;
        end
    end

    assign tx_ready = tx_ready_r;
    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;
    assign rx_err   = rx_err_r;
    assign line_out = line_out_r;
    assign line_oe  = line_oe_r;

endmodule
